// File: rtl/bus_keeper_array.sv
// rtl/bus_keeper_array.sv - per-channel bus keeper with hold timeout and decay; optional BUS_KEEPER_DECAY_EVT_EN adds decay_evt
module bus_keeper_array #(
  parameter int                WIDTH        = 16,
  parameter int                CHANNELS     = 4,
  parameter int                DECAY_CYCLES = 50,
  parameter logic [WIDTH-1:0]  DECAY_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       drv_en,
  input  logic [CHANNELS*WIDTH-1:0] drv_data,
  output logic [CHANNELS*WIDTH-1:0] bus_q,
  output logic [CHANNELS-1:0]       held,
  output logic [CHANNELS-1:0]       decayed
`ifdef BUS_KEEPER_DECAY_EVT_EN
  ,
  output logic [CHANNELS-1:0]       decay_evt
`endif
);

  localparam int AGE_W = (DECAY_CYCLES < 1) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [AGE_W-1:0] DECAY_AGE = AGE_W'(DECAY_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;
  localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVEN  = 2'd1,
    ST_HELD    = 2'd2,
    ST_DECAYED = 2'd3
  } state_t;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t             state_q, state_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               held_q, decayed_q;

    always_comb begin
      state_d = state_q;
      age_d   = age_q;
      data_d  = data_q;
      // A drive always wins, including on the edge a held value would decay.
      if (drv_en[k]) begin
        state_d = ST_DRIVEN;
        data_d  = drv_data[k*WIDTH +: WIDTH];
        age_d   = '0;
      end else begin
        case (state_q)
          ST_DRIVEN: begin
            state_d = ST_HELD;
            age_d   = AGE_ONE;
          end
          ST_HELD: begin
            if (DECAY_CYCLES != 0 && age_q == DECAY_AGE) begin
              state_d = ST_DECAYED;
              data_d  = DECAY_VALUE;
              age_d   = '0;
            end else if (age_q != AGE_MAX) begin
              age_d = age_q + AGE_ONE;
            end
          end
          default: data_d = DECAY_VALUE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        age_q     <= '0;
        data_q    <= DECAY_VALUE;
        held_q    <= 1'b0;
        decayed_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        age_q     <= age_d;
        data_q    <= data_d;
        held_q    <= (state_d == ST_HELD);
        decayed_q <= (state_d == ST_DECAYED);
      end
    end

    assign bus_q[k*WIDTH +: WIDTH] = data_q;
    assign held[k]                 = held_q;
    assign decayed[k]              = decayed_q;

`ifdef BUS_KEEPER_DECAY_EVT_EN
    logic evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        evt_q <= 1'b0;
      end else begin
        evt_q <= (state_d == ST_DECAYED) && (state_q != ST_DECAYED);
      end
    end

    assign decay_evt[k] = evt_q;
`endif
  end

endmodule

// File: tb/tb_bus_keeper_array.sv
// tb/tb_bus_keeper_array.sv - randomized and directed bench for bus_keeper_array
module tb_bus_keeper_array;

  localparam int DC_A = 50;

  logic        clk;
  logic        rst_n;

  logic [3:0]  en_a;
  logic [63:0] data_a, q_a;
  logic [3:0]  held_a, dec_a, evt_a;

  logic [3:0]  en_z;
  logic [63:0] data_z, q_z;
  logic [3:0]  held_z, dec_z, evt_z;

  logic [7:0]  en_n;
  logic [23:0] data_n, q_n;
  logic [7:0]  held_n, dec_n, evt_n;

  int n_vec = 0;
  int n_err = 0;

  bus_keeper_array dut_a (
    .clk(clk), .rst_n(rst_n), .drv_en(en_a), .drv_data(data_a),
    .bus_q(q_a), .held(held_a), .decayed(dec_a)
`ifdef BUS_KEEPER_DECAY_EVT_EN
    , .decay_evt(evt_a)
`endif
  );

  bus_keeper_array #(.DECAY_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .drv_en(en_z), .drv_data(data_z),
    .bus_q(q_z), .held(held_z), .decayed(dec_z)
`ifdef BUS_KEEPER_DECAY_EVT_EN
    , .decay_evt(evt_z)
`endif
  );

  bus_keeper_array #(.WIDTH(3), .CHANNELS(8), .DECAY_CYCLES(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .drv_en(en_n), .drv_data(data_n),
    .bus_q(q_n), .held(held_n), .decayed(dec_n)
`ifdef BUS_KEEPER_DECAY_EVT_EN
    , .decay_evt(evt_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a channel is just "last driven value" plus "undriven edges since".
  bit          ever[4];
  logic [15:0] val[4];
  int          run[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      ever[k] = 1'b0;
      val[k]  = '0;
      run[k]  = 0;
    end
  endtask

  task automatic compare_a();
    logic [63:0] eq;
    logic [3:0]  eh, ed, ee;
    eq = '0; eh = '0; ed = '0; ee = '0;
    for (int k = 0; k < 4; k++) begin
      if (!ever[k]) begin
        eq[k*16 +: 16] = 16'h0000;
      end else if (run[k] == 0) begin
        eq[k*16 +: 16] = val[k];
      end else if (run[k] <= DC_A) begin
        eq[k*16 +: 16] = val[k];
        eh[k] = 1'b1;
      end else begin
        ed[k] = 1'b1;
        ee[k] = (run[k] == DC_A + 1);
      end
    end
    check("a_bus_q", q_a, eq);
    check("a_held", held_a, eh);
    check("a_decayed", dec_a, ed);
`ifdef BUS_KEEPER_DECAY_EVT_EN
    check("a_decay_evt", evt_a, ee);
`endif
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic step_a(input logic [3:0] en, input logic [63:0] data);
    en_a   = en;
    data_a = data;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        ever[k] = 1'b1;
        val[k]  = data[k*16 +: 16];
        run[k]  = 0;
      end else if (ever[k] && run[k] < 10000) begin
        run[k]++;
      end
    end
    @(negedge clk);
    compare_a();
  endtask

  initial begin
    int hc, ec, co;
    logic prev_dec;
    rst_n  = 1'b0;
    en_a = '0; data_a = '0;
    en_z = '0; data_z = '0;
    en_n = '0; data_n = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_a_bus_q", q_a, 64'h0);
    check("rst_a_held", held_a, 4'h0);
    check("rst_a_decayed", dec_a, 4'h0);
    check("rst_n_bus_q", q_n, 24'h0);
    check("rst_z_held", held_z, 4'h0);
    rst_n = 1'b1;

    // ch0: drive one cycle, release, count held cycles, then decay
    step_a(4'b0001, 64'h0000_0000_0000_A5A5);
    check("ch0_drive", q_a[15:0], 16'hA5A5);
    hc = 0; ec = 0; co = 0; prev_dec = dec_a[0];
    for (int i = 0; i < 60; i++) begin
      step_a(4'b0000, 64'h0);
      if (held_a[0]) hc++;
`ifdef BUS_KEEPER_DECAY_EVT_EN
      if (evt_a[0]) ec++;
      if (evt_a[0] && dec_a[0] && !prev_dec) co++;
`endif
      prev_dec = dec_a[0];
    end
    check("ch0_held_cycles", hc, 50);
    check("ch0_decayed", dec_a[0], 1'b1);
    check("ch0_decay_value", q_a[15:0], 16'h0000);
`ifdef BUS_KEEPER_DECAY_EVT_EN
    check("ch0_evt_count", ec, 1);
    check("ch0_evt_coincident", co, 1);
`endif

    // ch1: re-drive on the 50th hold cycle, drive wins over decay
    step_a(4'b0010, 64'h0000_0000_BEEF_0000);
    for (int i = 0; i < 50; i++) step_a(4'b0000, 64'h0);
    check("ch1_held_at_50", held_a[1], 1'b1);
    step_a(4'b0010, 64'h0000_0000_1234_0000);
    check("ch1_redrive_q", q_a[31:16], 16'h1234);
    check("ch1_redrive_dec", dec_a[1], 1'b0);
    check("ch1_redrive_held", held_a[1], 1'b0);
    step_a(4'b0000, 64'h0);
    check("ch1_after_dec", dec_a[1], 1'b0);

    // ch2: reset mid-hold
    step_a(4'b0100, 64'h0000_5A5A_0000_0000);
    for (int i = 0; i < 20; i++) step_a(4'b0000, 64'h0);
    check("ch2_held_pre_rst", held_a[2], 1'b1);
    rst_n = 1'b0;
    #1;
    check("ch2_rst_bus_q", q_a, 64'h0);
    check("ch2_rst_held", held_a, 4'h0);
    check("ch2_rst_dec", dec_a, 4'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ec = 0;
    for (int i = 0; i < 60; i++) begin
      step_a(4'b0000, 64'h0);
`ifdef BUS_KEEPER_DECAY_EVT_EN
      if (evt_a[2]) ec++;
`endif
    end
    check("ch2_no_evt_after_rst", ec, 0);
    step_a(4'b0100, 64'h0000_7777_0000_0000);
    check("ch2_first_drive", q_a[47:32], 16'h7777);

    // randomized traffic against the reference
    for (int i = 0; i < 2500; i++) begin
      logic [3:0] en;
      for (int k = 0; k < 4; k++) en[k] = ($urandom_range(0, 45) == 0);
      if ($urandom_range(0, 199) == 0) en = 4'hF;
      step_a(en, {$urandom, $urandom});
    end

    // DECAY_CYCLES=0: hold forever
    en_z = 4'b1000; data_z = 64'hFFFF_0000_0000_0000;
    @(negedge clk);
    en_z = '0; data_z = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("z_held", held_z[3], 1'b1);
      check("z_bus_q", q_z[63:48], 16'hFFFF);
    end
    check("z_decayed", dec_z, 4'h0);

    // DECAY_CYCLES=1, 8 channels of 3 bits
    en_n = 8'hFF; data_n = {8{3'b101}};
    @(negedge clk);
    en_n = '0; data_n = '0;
    check("n_driven_q", q_n, {8{3'b101}});
    check("n_driven_held", held_n, 8'h00);
    @(negedge clk);
    check("n_held", held_n, 8'hFF);
    check("n_held_q", q_n, {8{3'b101}});
    check("n_held_dec", dec_n, 8'h00);
    @(negedge clk);
    check("n_dec", dec_n, 8'hFF);
    check("n_dec_held", held_n, 8'h00);
    check("n_dec_q", q_n, 24'h0);
`ifdef BUS_KEEPER_DECAY_EVT_EN
    check("n_evt", evt_n, 8'hFF);
`endif
    @(negedge clk);
    check("n_dec_stay", dec_n, 8'hFF);
`ifdef BUS_KEEPER_DECAY_EVT_EN
    check("n_evt_clear", evt_n, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_keeper_array.md
BUS_KEEPER_ARRAY -- requirements
Module: bus_keeper_array

Interface
- REQ-001 SHALL have parameter WIDTH, default 16: bits per channel.
- REQ-002 SHALL have parameter CHANNELS, default 4: number of independent kept buses.
- REQ-003 SHALL have parameter DECAY_CYCLES, default 50: undriven cycles before held charge decays; 0 means hold forever.
- REQ-004 SHALL have parameter DECAY_VALUE, default all-zero WIDTH bits: value presented after decay.
- REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-007 SHALL have port drv_en, input, CHANNELS bits: per-channel driver enable.
- REQ-008 SHALL have port drv_data, input, CHANNELS*WIDTH bits: channel k at bits [k*WIDTH +: WIDTH].
- REQ-009 SHALL have port bus_q, output, CHANNELS*WIDTH bits: registered kept value per channel.
- REQ-010 SHALL have port held, output, CHANNELS bits: channel in HELD state.
- REQ-011 SHALL have port decayed, output, CHANNELS bits: channel in DECAYED state.

Function
- REQ-012 SHALL keep one 2-bit state per channel: IDLE, DRIVEN, HELD, DECAYED.
- REQ-013 SHALL keep one age counter per channel, width clog2(DECAY_CYCLES+1), minimum 1 bit.
- REQ-014 SHALL, on any state with drv_en[k]=1, go to DRIVEN, load bus_q[k] from drv_data[k] and clear age; bus_q visible one cycle after sampling.
- REQ-015 SHALL, in DRIVEN with drv_en[k]=0, go to HELD, keep bus_q[k], set age to 1.
- REQ-016 SHALL, in HELD with drv_en[k]=0, increment age; on the edge where age equals DECAY_CYCLES, go to DECAYED, load DECAY_VALUE, clear age.
- REQ-017 SHALL, when DECAY_CYCLES=0, never leave HELD except by re-drive; age saturates, no wrap.
- REQ-018 SHALL, in IDLE or DECAYED with drv_en[k]=0, stay and hold DECAY_VALUE.
- REQ-019 SHALL treat re-drive in HELD on the decay edge as drive: drive wins over decay.
- REQ-020 SHALL make channels fully independent; simultaneous events on all channels are legal.
- REQ-021 SHALL drive held[k] and decayed[k] as registered decodes of state, same cycle as bus_q.
- REQ-022 SHALL support DECAY_CYCLES=1: HELD lasts exactly one cycle.

Reset
- REQ-023 SHALL, while rst_n=0, asynchronously force all states to IDLE, all age to 0, bus_q to DECAY_VALUE, held and decayed to 0.
- REQ-024 SHALL discard in-progress HELD timing on mid-operation reset; the first drv_en after release behaves as from IDLE.
- REQ-025 SHALL sample inputs on the first rising clk edge after rst_n deasserts.

Configuration
- REQ-026 SHALL, with macro BUS_KEEPER_DECAY_EVT_EN defined, add output decay_evt, CHANNELS bits, pulsing high one cycle when channel k enters DECAYED, reset 0.
- REQ-027 SHALL, without BUS_KEEPER_DECAY_EVT_EN, omit port decay_evt and its logic; all other behaviour identical.

Verification
- REQ-028 SHALL cover: defaults, drive ch0=16'hA5A5 one cycle then release -> bus_q ch0=A5A5, held=1 for 50 cycles, then decayed=1 and bus_q=0000.
- REQ-029 SHALL cover: ch1 released, re-driven 16'h1234 on cycle 50 of hold -> DRIVEN, bus_q=1234, decayed stays 0.
- REQ-030 SHALL cover: rst_n pulsed low mid-HELD on ch2 (cycle 20) -> immediate bus_q=0000, held=0; no decay_evt afterwards.
- REQ-031 SHALL cover: DECAY_CYCLES=0, ch3 driven 16'hFFFF then released 1000 cycles -> held stays 1, bus_q=FFFF.
- REQ-032 SHALL cover: DECAY_CYCLES=1, CHANNELS=8, WIDTH=3, all channels driven 3'b101 and released together -> held=8'hFF one cycle, then decayed=8'hFF.
- REQ-033 SHALL cover: BUS_KEEPER_DECAY_EVT_EN defined, REQ-028 stimulus -> decay_evt[0] high exactly one cycle, coincident with decayed[0] rising.
